// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: turns a shadowed configuration word into static, blink,
// chase and breathe effects paced by a prescaled step tick.
module led_pattern_sequencer #(
    parameter int NUM_LEDS       = 8,
    parameter int PWM_RESOLUTION = 8,
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int TICK_HZ        = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [1:0]                cfg_mode,
    input  logic [NUM_LEDS-1:0]       cfg_pattern,
    input  logic [15:0]               cfg_period,
    input  logic [PWM_RESOLUTION-1:0] cfg_duty,
    output logic [NUM_LEDS-1:0]       led_control,
    output logic [PWM_RESOLUTION-1:0] pwm_duty,
    output logic                      step_pulse
);

    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRESC_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]        PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0]        PRESC_ONE = PRESC_W'(1);
    localparam logic [PWM_RESOLUTION-1:0] LEVEL_ONE = PWM_RESOLUTION'(1);

    localparam logic [1:0] MODE_STATIC  = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                      state_reg, state_next;
    logic                        cfg_ready_reg, cfg_ready_next;
    logic [1:0]                  mode_reg, mode_next;
    logic [NUM_LEDS-1:0]         pattern_reg, pattern_next;
    logic [15:0]                 period_reg, period_next;
    logic [PWM_RESOLUTION-1:0]   duty_reg, duty_next;
    logic [PRESC_W-1:0]          presc_reg, presc_next;
    logic [15:0]                 step_cnt_reg, step_cnt_next;
    logic [NUM_LEDS-1:0]         chase_reg, chase_next;
    logic                        phase_reg, phase_next;
    logic [PWM_RESOLUTION-1:0]   level_reg, level_next;
    logic                        dir_up_reg, dir_up_next;
    logic [NUM_LEDS-1:0]         led_control_reg, led_control_next;
    logic [PWM_RESOLUTION-1:0]   pwm_duty_reg, pwm_duty_next;
    logic                        step_pulse_reg, step_pulse_next;

    logic        accept;
    logic        tick;
    logic        step_wrap;
    logic        step_event;
    logic [15:0] period_eff;

    assign accept     = cfg_valid && cfg_ready_reg;
    assign period_eff = (period_reg == 16'd0) ? 16'd1 : period_reg;
    assign tick       = (state_reg == ST_RUN) && (presc_reg == PRESC_MAX);
    assign step_wrap  = (step_cnt_reg == (period_eff - 16'd1));
    assign step_event = tick && step_wrap && enable;

    always_comb begin
        state_next       = state_reg;
        cfg_ready_next   = 1'b1;
        mode_next        = mode_reg;
        pattern_next     = pattern_reg;
        period_next      = period_reg;
        duty_next        = duty_reg;
        presc_next       = presc_reg;
        step_cnt_next    = step_cnt_reg;
        chase_next       = chase_reg;
        phase_next       = phase_reg;
        level_next       = level_reg;
        dir_up_next      = dir_up_reg;
        led_control_next = '0;
        pwm_duty_next    = '0;
        step_pulse_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                presc_next    = '0;
                step_cnt_next = '0;
                if (enable) begin
                    state_next  = ST_RUN;
                    chase_next  = pattern_reg;
                    phase_next  = 1'b1;
                    level_next  = '0;
                    dir_up_next = 1'b1;
                end
            end
            default: begin
                if (!enable) begin
                    state_next    = ST_IDLE;
                    presc_next    = '0;
                    step_cnt_next = '0;
                end else begin
                    presc_next = tick ? '0 : presc_reg + PRESC_ONE;
                    if (tick)
                        step_cnt_next = step_wrap ? 16'd0 : step_cnt_reg + 16'd1;
                    if (step_event) begin
                        step_pulse_next = 1'b1;
                        chase_next      = {chase_reg[NUM_LEDS-2:0], chase_reg[NUM_LEDS-1]};
                        phase_next      = ~phase_reg;
                        // Triangle wave between 0 and duty; duty of 0 pins the level.
                        if (duty_reg == '0) begin
                            level_next  = '0;
                            dir_up_next = 1'b1;
                        end else if (dir_up_reg) begin
                            level_next = level_reg + LEVEL_ONE;
                            if ((level_reg + LEVEL_ONE) >= duty_reg)
                                dir_up_next = 1'b0;
                        end else if (level_reg == '0) begin
                            level_next  = LEVEL_ONE;
                            dir_up_next = 1'b1;
                        end else begin
                            level_next = level_reg - LEVEL_ONE;
                            if (level_reg == LEVEL_ONE)
                                dir_up_next = 1'b1;
                        end
                    end
                end
            end
        endcase

        // A new config restarts the effect and discards a coincident step.
        if (accept) begin
            cfg_ready_next  = 1'b0;
            mode_next       = cfg_mode;
            pattern_next    = cfg_pattern;
            period_next     = cfg_period;
            duty_next       = cfg_duty;
            presc_next      = '0;
            step_cnt_next   = '0;
            chase_next      = cfg_pattern;
            phase_next      = 1'b1;
            level_next      = '0;
            dir_up_next     = 1'b1;
            step_pulse_next = 1'b0;
        end

        // Outputs are derived from the next-state values so they land one cycle after the event.
        if (state_next == ST_RUN) begin
            case (mode_next)
                MODE_STATIC: begin
                    led_control_next = pattern_next;
                    pwm_duty_next    = duty_next;
                end
                MODE_BLINK: begin
                    led_control_next = phase_next ? pattern_next : '0;
                    pwm_duty_next    = duty_next;
                end
                MODE_CHASE: begin
                    led_control_next = chase_next;
                    pwm_duty_next    = duty_next;
                end
                MODE_BREATHE: begin
                    led_control_next = pattern_next;
                    pwm_duty_next    = level_next;
                end
                default: begin
                    led_control_next = '0;
                    pwm_duty_next    = '0;
                end
            endcase
        end else begin
            step_pulse_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cfg_ready_reg   <= 1'b1;
            mode_reg        <= '0;
            pattern_reg     <= '0;
            period_reg      <= '0;
            duty_reg        <= '0;
            presc_reg       <= '0;
            step_cnt_reg    <= '0;
            chase_reg       <= '0;
            phase_reg       <= 1'b1;
            level_reg       <= '0;
            dir_up_reg      <= 1'b1;
            led_control_reg <= '0;
            pwm_duty_reg    <= '0;
            step_pulse_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cfg_ready_reg   <= cfg_ready_next;
            mode_reg        <= mode_next;
            pattern_reg     <= pattern_next;
            period_reg      <= period_next;
            duty_reg        <= duty_next;
            presc_reg       <= presc_next;
            step_cnt_reg    <= step_cnt_next;
            chase_reg       <= chase_next;
            phase_reg       <= phase_next;
            level_reg       <= level_next;
            dir_up_reg      <= dir_up_next;
            led_control_reg <= led_control_next;
            pwm_duty_reg    <= pwm_duty_next;
            step_pulse_reg  <= step_pulse_next;
        end
    end

    assign cfg_ready   = cfg_ready_reg;
    assign led_control = led_control_reg;
    assign pwm_duty    = pwm_duty_reg;
    assign step_pulse  = step_pulse_reg;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed, table-driven bench for led_pattern_sequencer with TICK_DIV = 10.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_pattern;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_duty;
    logic [7:0]  led_control;
    logic [7:0]  pwm_duty;
    logic        step_pulse;

    int checks = 0;
    int errors = 0;

    led_pattern_sequencer #(
        .NUM_LEDS(8),
        .PWM_RESOLUTION(8),
        .CLK_FREQ_HZ(1000),
        .TICK_HZ(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode),
        .cfg_pattern(cfg_pattern),
        .cfg_period(cfg_period),
        .cfg_duty(cfg_duty),
        .led_control(led_control),
        .pwm_duty(pwm_duty),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        do_cfg;
        logic [1:0]  mode;
        logic [7:0]  pat;
        logic [15:0] period;
        logic [7:0]  duty;
        int          n;
        logic [7:0]  e_led;
        logic [7:0]  e_duty;
        logic        e_step;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t cfg_vec(input logic [1:0] mode, input logic [7:0] pat,
                                     input logic [15:0] period, input logic [7:0] duty,
                                     input int n, input logic [7:0] e_led,
                                     input logic [7:0] e_duty, input logic e_step,
                                     input logic e_ready);
        vec_t v;
        v.en = 1'b1; v.do_cfg = 1'b1; v.mode = mode; v.pat = pat;
        v.period = period; v.duty = duty; v.n = n;
        v.e_led = e_led; v.e_duty = e_duty; v.e_step = e_step; v.e_ready = e_ready;
        return v;
    endfunction

    function automatic vec_t run_vec(input logic en, input int n, input logic [7:0] e_led,
                                     input logic [7:0] e_duty, input logic e_step);
        vec_t v;
        v.en = en; v.do_cfg = 1'b0; v.mode = 2'd0; v.pat = 8'h00;
        v.period = 16'd0; v.duty = 8'd0; v.n = n;
        v.e_led = e_led; v.e_duty = e_duty; v.e_step = e_step; v.e_ready = 1'b1;
        return v;
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [7:0] e_led,
                              input logic [7:0] e_duty, input logic e_step,
                              input logic e_ready);
        check_int({name, ".led_control"}, int'(led_control), int'(e_led));
        check_int({name, ".pwm_duty"},    int'(pwm_duty),    int'(e_duty));
        check_int({name, ".step_pulse"},  int'(step_pulse),  int'(e_step));
        check_int({name, ".cfg_ready"},   int'(cfg_ready),   int'(e_ready));
    endtask

    // Counts clock edges until step_pulse is seen, bounded so a dead DUT cannot hang the run.
    task automatic wait_step(output int cnt);
        cnt = 0;
        do begin
            step_clk();
            cnt++;
        end while (!step_pulse && cnt < 100);
    endtask

    initial begin
        int cnt;

        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_mode = 2'd0; cfg_pattern = 8'h00; cfg_period = 16'd0; cfg_duty = 8'd0;

        // STATIC
        vecs.push_back(cfg_vec(2'd0, 8'hA5, 16'd0, 8'd200, 0, 8'hA5, 8'd200, 1'b0, 1'b0));
        vecs.push_back(run_vec(1'b1, 1, 8'hA5, 8'd200, 1'b0));
        vecs.push_back(run_vec(1'b1, 8, 8'hA5, 8'd200, 1'b0));
        vecs.push_back(run_vec(1'b1, 1, 8'hA5, 8'd200, 1'b1));
        // BLINK, period 3
        vecs.push_back(cfg_vec(2'd1, 8'h0F, 16'd3, 8'd50, 0, 8'h0F, 8'd50, 1'b0, 1'b0));
        vecs.push_back(run_vec(1'b1, 29, 8'h0F, 8'd50, 1'b0));
        vecs.push_back(run_vec(1'b1, 1, 8'h00, 8'd50, 1'b1));
        vecs.push_back(run_vec(1'b1, 1, 8'h00, 8'd50, 1'b0));
        vecs.push_back(run_vec(1'b1, 29, 8'h0F, 8'd50, 1'b1));
        // CHASE, period 1, MSB wraps into LSB
        vecs.push_back(cfg_vec(2'd2, 8'h81, 16'd1, 8'd7, 0, 8'h81, 8'd7, 1'b0, 1'b0));
        vecs.push_back(run_vec(1'b1, 10, 8'h03, 8'd7, 1'b1));
        vecs.push_back(run_vec(1'b1, 10, 8'h06, 8'd7, 1'b1));
        vecs.push_back(run_vec(1'b1, 10, 8'h0C, 8'd7, 1'b1));
        // Accept lands on the step edge: accept wins, step is dropped
        vecs.push_back(cfg_vec(2'd2, 8'h81, 16'd1, 8'd7, 9, 8'h81, 8'd7, 1'b0, 1'b1));
        vecs.push_back(cfg_vec(2'd2, 8'h01, 16'd1, 8'd7, 0, 8'h01, 8'd7, 1'b0, 1'b0));
        vecs.push_back(run_vec(1'b1, 10, 8'h02, 8'd7, 1'b1));
        // Enable drop and re-raise restarts the chase at the loaded pattern
        vecs.push_back(cfg_vec(2'd2, 8'h81, 16'd1, 8'd7, 10, 8'h03, 8'd7, 1'b1, 1'b1));
        vecs.push_back(run_vec(1'b0, 1, 8'h00, 8'd0, 1'b0));
        vecs.push_back(run_vec(1'b0, 3, 8'h00, 8'd0, 1'b0));
        vecs.push_back(run_vec(1'b1, 1, 8'h81, 8'd7, 1'b0));
        vecs.push_back(run_vec(1'b1, 10, 8'h03, 8'd7, 1'b1));
        // BREATHE, ceiling 3
        vecs.push_back(cfg_vec(2'd3, 8'hFF, 16'd1, 8'd3, 0, 8'hFF, 8'd0, 1'b0, 1'b0));
        vecs.push_back(run_vec(1'b1, 10, 8'hFF, 8'd1, 1'b1));
        vecs.push_back(run_vec(1'b1, 10, 8'hFF, 8'd2, 1'b1));
        vecs.push_back(run_vec(1'b1, 10, 8'hFF, 8'd3, 1'b1));
        vecs.push_back(run_vec(1'b1, 10, 8'hFF, 8'd2, 1'b1));
        vecs.push_back(run_vec(1'b1, 10, 8'hFF, 8'd1, 1'b1));
        vecs.push_back(run_vec(1'b1, 10, 8'hFF, 8'd0, 1'b1));
        vecs.push_back(run_vec(1'b1, 10, 8'hFF, 8'd1, 1'b1));
        // BREATHE with zero ceiling holds level at 0
        vecs.push_back(cfg_vec(2'd3, 8'hFF, 16'd1, 8'd0, 0, 8'hFF, 8'd0, 1'b0, 1'b0));
        vecs.push_back(run_vec(1'b1, 10, 8'hFF, 8'd0, 1'b1));
        vecs.push_back(cfg_vec(2'd3, 8'hFF, 16'd1, 8'd3, 10, 8'hFF, 8'd1, 1'b1, 1'b1));

        repeat (3) step_clk();
        check_outs("reset", 8'h00, 8'd0, 1'b0, 1'b1);
        $display("reset: led=%h duty=%0d step=%0b ready=%0b", led_control, pwm_duty, step_pulse, cfg_ready);

        // Unconfigured run: period 0 behaves as 1, so steps every 10 cycles
        reset = 1'b0; enable = 1'b1;
        wait_step(cnt);
        check_int("first_step_latency", cnt, 11);
        check_outs("unconfigured", 8'h00, 8'd0, 1'b1, 1'b1);
        $display("unconfigured: first step after %0d cycles", cnt);
        wait_step(cnt);
        check_int("step_interval", cnt, 10);
        $display("unconfigured: next step after %0d cycles", cnt);

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en;
            if (vecs[i].do_cfg) begin
                cfg_mode    = vecs[i].mode;
                cfg_pattern = vecs[i].pat;
                cfg_period  = vecs[i].period;
                cfg_duty    = vecs[i].duty;
                cfg_valid   = 1'b1;
                step_clk();
                cfg_valid   = 1'b0;
            end
            repeat (vecs[i].n) step_clk();
            check_outs($sformatf("vec%0d", i), vecs[i].e_led, vecs[i].e_duty,
                       vecs[i].e_step, vecs[i].e_ready);
            $display("vec %0d: en=%0b cfg=%0b led=%h duty=%0d step=%0b ready=%0b",
                     i, vecs[i].en, vecs[i].do_cfg, led_control, pwm_duty, step_pulse, cfg_ready);
        end

        // Reset mid-run clears outputs and the shadow config (back to STATIC, pattern 0)
        reset = 1'b1;
        step_clk();
        check_outs("midrun_reset", 8'h00, 8'd0, 1'b0, 1'b1);
        $display("midrun reset: led=%h duty=%0d", led_control, pwm_duty);
        reset = 1'b0;
        step_clk();
        check_outs("after_reset_run", 8'h00, 8'd0, 1'b0, 1'b1);
        wait_step(cnt);
        check_int("after_reset_step", cnt, 10);
        check_outs("after_reset_stepped", 8'h00, 8'd0, 1'b1, 1'b1);
        $display("after reset: step after %0d cycles led=%h duty=%0d", cnt, led_control, pwm_duty);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
